chu_mmio_pipe_controller: RTL and testbench

Parametrised, pipelined successor to the MMIO slot controller. It decodes FPro bus requests into per-slot chip-select, read/write strobes, register address and write data. It returns registered read data and traps accesses to unpopulated slots or out-of-range addresses in a built-in error-capture slot. It sits between the FPro bus and the I/O core slots of the MMIO subsystem.

---
 rtl/chu_mmio_pipe_controller.sv | 149 ++++++++++++++
 tb/tb_chu_mmio_pipe_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/chu_mmio_pipe_controller.sv
// rtl/chu_mmio_pipe_controller.sv - pipelined FPro MMIO slot decoder with error-capture slot
module chu_mmio_pipe_controller #(
    parameter int SLOT_BITS = 6,
    parameter int REG_W = 5,
    localparam int N_SLOT = 2**SLOT_BITS,
    parameter logic [N_SLOT-1:0] POP_MASK = '1,
    parameter int ERR_SLOT = N_SLOT-1,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mmio_cs,
    input  logic                          mmio_wr,
    input  logic                          mmio_rd,
    input  logic [20:0]                   mmio_addr,
    input  logic [31:0]                   mmio_wr_data,
    output logic [31:0]                   mmio_rd_data,
    output logic [N_SLOT-1:0]             slot_cs_array,
    output logic [N_SLOT-1:0]             slot_mem_rd_array,
    output logic [N_SLOT-1:0]             slot_mem_wr_array,
    output logic [N_SLOT-1:0][REG_W-1:0]  slot_reg_addr_array,
    output logic [N_SLOT-1:0][31:0]       slot_wr_data_array,
    input  logic [N_SLOT-1:0][31:0]       slot_rd_data_array,
    output logic                          err_irq
);

    localparam logic [SLOT_BITS-1:0] ERR_IDX = SLOT_BITS'(ERR_SLOT);
    // The error slot is served internally, so it never counts as populated.
    localparam logic [N_SLOT-1:0] POP_EFF = POP_MASK & ~(N_SLOT'(1) << ERR_SLOT);

    logic                 req;
    logic                 req_fault;
    logic                 req_err_slot;
    logic                 req_clr;
    logic [SLOT_BITS-1:0] req_slot;
    logic [REG_W-1:0]     req_reg;

    logic                 s1_valid;
    logic                 s1_wr;
    logic                 s1_fault;
    logic [SLOT_BITS-1:0] s1_slot;
    logic [REG_W-1:0]     s1_reg;
    logic [31:0]          s1_data;

    logic                 err_flag;
    logic [15:0]          err_cnt;
    logic [20:0]          err_addr;
    logic [31:0]          acc_cnt;
    logic [31:0]          err_rd_data;
    logic                 s1_hit;

    always_comb begin
        req          = mmio_cs & (mmio_wr | mmio_rd);
        req_slot     = mmio_addr[REG_W +: SLOT_BITS];
        req_reg      = mmio_addr[REG_W-1:0];
        req_err_slot = (req_slot == ERR_IDX);
        req_fault    = (|(mmio_addr >> (REG_W + SLOT_BITS))) |
                       (!POP_EFF[req_slot] & !req_err_slot);
        req_clr      = req & mmio_wr & !req_fault & req_err_slot & (req_reg == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_wr    <= 1'b0;
            s1_fault <= 1'b0;
            s1_slot  <= '0;
            s1_reg   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= req;
            if (req) begin
                s1_wr    <= mmio_wr;
                s1_fault <= req_fault;
                s1_slot  <= req_slot;
                s1_reg   <= req_reg;
                s1_data  <= mmio_wr_data;
            end
        end
    end

    always_comb begin
        slot_cs_array     = '0;
        slot_mem_rd_array = '0;
        slot_mem_wr_array = '0;
        s1_hit            = s1_valid & !s1_fault & (s1_slot != ERR_IDX);
        if (s1_hit) begin
            slot_cs_array[s1_slot] = 1'b1;
            if (s1_wr)
                slot_mem_wr_array[s1_slot] = 1'b1;
            else
                slot_mem_rd_array[s1_slot] = 1'b1;
        end
        for (int i = 0; i < N_SLOT; i++) begin
            slot_reg_addr_array[i] = s1_reg;
            slot_wr_data_array[i]  = s1_data;
        end
    end

    // Error capture tracks the incoming request so err_irq follows one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            acc_cnt  <= '0;
        end else begin
            if (req && !req_fault)
                acc_cnt <= acc_cnt + 32'd1;
            if (req_clr) begin
                err_flag <= 1'b0;
                err_cnt  <= '0;
                err_addr <= '0;
            end else if (req && req_fault) begin
                err_flag <= 1'b1;
                if (err_cnt != 16'hFFFF)
                    err_cnt <= err_cnt + 16'd1;
                if (!err_flag)
                    err_addr <= mmio_addr;
            end
        end
    end

    always_comb begin
        err_rd_data = '0;
        if (s1_reg == REG_W'(0))
            err_rd_data = {15'b0, err_flag, err_cnt};
        else if (s1_reg == REG_W'(1))
            err_rd_data = {11'b0, err_addr};
        else if (s1_reg == REG_W'(2))
            err_rd_data = acc_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_rd_data <= '0;
        end else if (s1_valid && !s1_wr) begin
            if (s1_fault)
                mmio_rd_data <= ERR_DATA;
            else if (s1_slot == ERR_IDX)
                mmio_rd_data <= err_rd_data;
            else
                mmio_rd_data <= slot_rd_data_array[s1_slot];
        end
    end

    assign err_irq = err_flag;

endmodule

// File: tb/tb_chu_mmio_pipe_controller.sv
// tb/tb_chu_mmio_pipe_controller.sv - directed bench for chu_mmio_pipe_controller
module tb_chu_mmio_pipe_controller;

    localparam int N_SLOT = 64;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        mmio_cs;
    logic                        mmio_wr;
    logic                        mmio_rd;
    logic [20:0]                 mmio_addr;
    logic [31:0]                 mmio_wr_data;
    logic [31:0]                 mmio_rd_data;
    logic [N_SLOT-1:0]           slot_cs_array;
    logic [N_SLOT-1:0]           slot_mem_rd_array;
    logic [N_SLOT-1:0]           slot_mem_wr_array;
    logic [N_SLOT-1:0][4:0]      slot_reg_addr_array;
    logic [N_SLOT-1:0][31:0]     slot_wr_data_array;
    logic [N_SLOT-1:0][31:0]     slot_rd_data_array;
    logic                        err_irq;

    int checks = 0;
    int errors = 0;

    chu_mmio_pipe_controller #(
        .POP_MASK(~(64'h80))
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mmio_cs             (mmio_cs),
        .mmio_wr             (mmio_wr),
        .mmio_rd             (mmio_rd),
        .mmio_addr           (mmio_addr),
        .mmio_wr_data        (mmio_wr_data),
        .mmio_rd_data        (mmio_rd_data),
        .slot_cs_array       (slot_cs_array),
        .slot_mem_rd_array   (slot_mem_rd_array),
        .slot_mem_wr_array   (slot_mem_wr_array),
        .slot_reg_addr_array (slot_reg_addr_array),
        .slot_wr_data_array  (slot_wr_data_array),
        .slot_rd_data_array  (slot_rd_data_array),
        .err_irq             (err_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic rd, input logic [20:0] addr, input logic [31:0] data);
        mmio_cs      = 1'b1;
        mmio_wr      = wr;
        mmio_rd      = rd;
        mmio_addr    = addr;
        mmio_wr_data = data;
    endtask

    task automatic idle();
        mmio_cs = 1'b0;
        mmio_wr = 1'b0;
        mmio_rd = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [20:0] addr, input logic [31:0] exp);
        bus(1'b0, 1'b1, addr, 32'h0);
        step();
        idle();
        step();
        check(tag, {32'h0, mmio_rd_data}, {32'h0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        mmio_addr    = '0;
        mmio_wr_data = '0;
        idle();
        for (int i = 0; i < N_SLOT; i++)
            slot_rd_data_array[i] = 32'h5100_0000 + i;
        slot_rd_data_array[5] = 32'hA5A5_0001;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        step();

        check("rst_cs", slot_cs_array, 64'h0);
        check("rst_rd", slot_mem_rd_array, 64'h0);
        check("rst_wr", slot_mem_wr_array, 64'h0);
        check("rst_rdata", {32'h0, mmio_rd_data}, 64'h0);
        check("rst_irq", {63'h0, err_irq}, 64'h0);
        check("rst_regaddr", {63'h0, |slot_reg_addr_array}, 64'h0);
        check("rst_wdata", {63'h0, |slot_wr_data_array}, 64'h0);

        bus(1'b1, 1'b0, 21'h043, 32'h1234_5678);
        step();
        idle();
        check("wr_cs", slot_cs_array, 64'h4);
        check("wr_strobe", slot_mem_wr_array, 64'h4);
        check("wr_no_rd", slot_mem_rd_array, 64'h0);
        check("wr_regaddr", {59'h0, slot_reg_addr_array[2]}, 64'h3);
        check("wr_regaddr_bcast", {59'h0, slot_reg_addr_array[60]}, 64'h3);
        check("wr_data", {32'h0, slot_wr_data_array[2]}, 64'h1234_5678);
        step();
        check("wr_one_cycle_cs", slot_cs_array, 64'h0);
        check("wr_one_cycle_wr", slot_mem_wr_array, 64'h0);

        bus(1'b0, 1'b1, 21'h0A0, 32'h0);
        step();
        idle();
        check("rd_strobe", slot_mem_rd_array, 64'h20);
        check("rd_cs", slot_cs_array, 64'h20);
        step();
        check("rd_data", {32'h0, mmio_rd_data}, 64'hA5A5_0001);

        bus(1'b0, 1'b1, 21'h0E4, 32'h0);
        step();
        idle();
        check("flt_cs", slot_cs_array, 64'h0);
        check("flt_rd", slot_mem_rd_array, 64'h0);
        check("flt_irq", {63'h0, err_irq}, 64'h1);
        step();
        check("flt_data", {32'h0, mmio_rd_data}, 64'hDEAD_BEEF);
        rd_check("flt_addr", 21'h7E1, 32'h0000_00E4);
        rd_check("flt_reg0", 21'h7E0, 32'h0001_0001);

        bus(1'b0, 1'b1, 21'h1000, 32'h0);
        step();
        idle();
        check("oor_irq", {63'h0, err_irq}, 64'h1);
        check("oor_cs", slot_cs_array, 64'h0);
        step();
        check("oor_data", {32'h0, mmio_rd_data}, 64'hDEAD_BEEF);
        rd_check("oor_reg0", 21'h7E0, 32'h0001_0002);
        rd_check("oor_addr_kept", 21'h7E1, 32'h0000_00E4);

        bus(1'b1, 1'b0, 21'h7E0, 32'hFFFF_FFFF);
        step();
        idle();
        check("clr_irq", {63'h0, err_irq}, 64'h0);
        check("clr_no_strobe", slot_mem_wr_array, 64'h0);
        step();
        rd_check("clr_reg0", 21'h7E0, 32'h0);
        rd_check("clr_addr", 21'h7E1, 32'h0);

        rd_check("both_pre", 21'h0A0, 32'hA5A5_0001);
        bus(1'b1, 1'b1, 21'h020, 32'hCAFE_0000);
        step();
        idle();
        check("both_wr", slot_mem_wr_array, 64'h2);
        check("both_no_rd", slot_mem_rd_array, 64'h0);
        step();
        check("both_rdata_hold", {32'h0, mmio_rd_data}, 64'hA5A5_0001);

        bus(1'b1, 1'b0, 21'h043, 32'h1);
        step();
        idle();
        check("mid_wr", slot_mem_wr_array, 64'h4);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_wr", slot_mem_wr_array, 64'h0);
        check("mid_rst_cs", slot_cs_array, 64'h0);
        check("mid_rst_rdata", {32'h0, mmio_rd_data}, 64'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i <= 4; i++) begin
            if (i < 4)
                bus(1'b0, 1'b1, 21'(i * 32), 32'h0);
            else
                idle();
            step();
            if (i < 4)
                check("b2b_strobe", slot_mem_rd_array, 64'h1 << i);
            if (i >= 1)
                check("b2b_data", {32'h0, mmio_rd_data}, {32'h0, 32'h5100_0000 + 32'(i - 1)});
        end
        // Four slot reads plus the counter read itself.
        rd_check("acc_cnt", 21'h7E2, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
